// File: rtl/face_rect_pkg.sv
// Shared types and default constants for the face-rectangle overlay controller.
package face_rect_pkg;

  localparam int H_ACTIVE_DEF    = 640;
  localparam int V_ACTIVE_DEF    = 480;
  localparam int HOLD_FRAMES_DEF = 3;
  localparam int CW_DEF          = 12;

  // Overlay controller state; SEARCH is the only state with nothing drawn.
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    HOLD   = 2'd2,
    FROZEN = 2'd3
  } rect_state_t;

  // One detector result as held in the shadow register.
  typedef struct packed {
    logic              found;
    logic [CW_DEF-1:0] x;
    logic [CW_DEF-1:0] y;
    logic [CW_DEF-1:0] w;
    logic [CW_DEF-1:0] h;
  } det_result_t;

endpackage

// File: rtl/face_rect_ctrl_rect_clamp.sv
// Combinational clamp of a detector box to the visible frame. Works in
// CW+1 bits so that the "room left" subtraction can never wrap.
module rect_clamp #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CW       = 12
) (
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic [CW-1:0] w,
  input  logic [CW-1:0] h,
  output logic [CW-1:0] x_c,
  output logic [CW-1:0] y_c,
  output logic [CW-1:0] w_c,
  output logic [CW-1:0] h_c
);

  localparam logic [CW:0] H_LIM = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] V_LIM = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] H_MAX = (CW+1)'(H_ACTIVE - 1);
  localparam logic [CW:0] V_MAX = (CW+1)'(V_ACTIVE - 1);

  logic [CW:0] x_m, y_m, w_room, h_room, w_m, h_m;

  // Origin is pulled inside the frame first, then the size is limited to the room left.
  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    x_m    = ({1'b0, x} > H_MAX) ? H_MAX : {1'b0, x};
    y_m    = ({1'b0, y} > V_MAX) ? V_MAX : {1'b0, y};
    w_room = H_LIM - x_m;
    h_room = V_LIM - y_m;
    w_m    = ({1'b0, w} > w_room) ? w_room : {1'b0, w};
    h_m    = ({1'b0, h} > h_room) ? h_room : {1'b0, h};
    x_c    = CW'(x_m);
    y_c    = CW'(y_m);
    w_c    = CW'(w_m);
    h_c    = CW'(h_m);
  end

endmodule

// File: rtl/face_rect_ctrl.sv
// Frame-synchronous controller for the rectangle overlay. Detector results
// land in a shadow register via valid/ready and are only acted on at the
// vsync rising edge, so the drawn rectangle never changes mid-frame.
// The shadow register uses the package result type, so CW is expected to
// equal CW_DEF.
module face_rect_ctrl
  import face_rect_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int HOLD_FRAMES = HOLD_FRAMES_DEF,
  parameter int CW          = CW_DEF
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          vsync_in,
  input  logic          det_valid,
  output logic          det_ready,
  input  logic          det_found,
  input  logic [CW-1:0] det_x,
  input  logic [CW-1:0] det_y,
  input  logic [CW-1:0] det_w,
  input  logic [CW-1:0] det_h,
  input  logic          mode_continuous,
  input  logic          clear,
  output logic [CW-1:0] rect_x,
  output logic [CW-1:0] rect_y,
  output logic [CW-1:0] rect_w,
  output logic [CW-1:0] rect_h,
  output logic          detected_flag,
  output logic          continuous,
  output logic          frame_tick
);

  localparam int              MCW      = $clog2(HOLD_FRAMES + 2);
  localparam logic [MCW-1:0]  MISS_SAT = MCW'(HOLD_FRAMES + 1);
  localparam logic [MCW-1:0]  MISS_MAX = MCW'(HOLD_FRAMES);

  logic            vsync_d;
  logic            armed;
  logic            pending;
  logic            pending_nxt;
  logic            xfer;
  logic            hit;
  det_result_t     shadow;
  rect_state_t     state;
  logic [MCW-1:0]  miss_cnt;
  logic [MCW-1:0]  miss_inc;
  logic            miss_drop;
  logic [CW-1:0]   cx, cy, cw, ch;

  // armed masks the first cycle after reset so a vsync that is already high
  // at release is not mistaken for a rising edge.
  assign frame_tick = vsync_in & ~vsync_d & armed;
  assign xfer       = det_valid & det_ready;
  assign hit        = pending & shadow.found & (|shadow.w) & (|shadow.h);

  // Vsync edge detector and post-reset arming.
  always_ff @(posedge pclk or negedge rst_n) begin
    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    if (!rst_n) begin
      vsync_d <= 1'b0;
      armed   <= 1'b0;
    end else begin
      vsync_d <= vsync_in;
      armed   <= 1'b1;
    end
  end

  // Next pending: a tick drains the shadow, a transfer refills it.
  always_comb begin
    pending_nxt = pending;
    if (frame_tick) pending_nxt = 1'b0;
    if (xfer)       pending_nxt = 1'b1;
  end

  // Shadow register and registered ready (low throughout reset).
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      det_ready <= 1'b0;
      shadow    <= '0;
    end else begin
      pending   <= pending_nxt;
      det_ready <= ~pending_nxt;
      if (xfer) begin
        shadow.found <= det_found;
        shadow.x     <= det_x;
        shadow.y     <= det_y;
        shadow.w     <= det_w;
        shadow.h     <= det_h;
      end
    end
  end

  // Saturating miss counter increment and the drop decision.
  always_comb begin
    miss_inc  = (miss_cnt >= MISS_SAT) ? MISS_SAT : miss_cnt + 1'b1;
    miss_drop = (miss_inc > MISS_MAX);
  end

  rect_clamp #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .CW       (CW)
  ) u_clamp (
    .x   (shadow.x),
    .y   (shadow.y),
    .w   (shadow.w),
    .h   (shadow.h),
    .x_c (cx),
    .y_c (cy),
    .w_c (cw),
    .h_c (ch)
  );

  // Mode is sampled once per frame so the draw stage sees a stable value.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)          continuous <= 1'b0;
    else if (frame_tick) continuous <= mode_continuous;
  end

  // Tracking FSM; advances on frame_tick, except clear releasing FROZEN at once.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= SEARCH;
      miss_cnt      <= '0;
      detected_flag <= 1'b0;
      rect_x        <= '0;
      rect_y        <= '0;
      rect_w        <= '0;
      rect_h        <= '0;
    end else if (state == FROZEN && clear) begin
      state         <= SEARCH;
      detected_flag <= 1'b0;
    end else if (frame_tick) begin
      case (state)
        SEARCH: begin
          if (hit) begin
            state         <= mode_continuous ? TRACK : FROZEN;
            detected_flag <= 1'b1;
            miss_cnt      <= '0;
            rect_x        <= cx;
            rect_y        <= cy;
            rect_w        <= cw;
            rect_h        <= ch;
          end
        end
        TRACK: begin
          if (hit) begin
            miss_cnt <= '0;
            rect_x   <= cx;
            rect_y   <= cy;
            rect_w   <= cw;
            rect_h   <= ch;
          end else begin
            miss_cnt <= MCW'(1);
            if (HOLD_FRAMES > 0) begin
              state <= HOLD;
            end else begin
              state         <= SEARCH;
              detected_flag <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (hit) begin
            state    <= TRACK;
            miss_cnt <= '0;
            rect_x   <= cx;
            rect_y   <= cy;
            rect_w   <= cw;
            rect_h   <= ch;
          end else begin
            miss_cnt <= miss_inc;
            if (miss_drop) begin
              state         <= SEARCH;
              detected_flag <= 1'b0;
            end
          end
        end
        FROZEN: begin
          if (mode_continuous) begin
            state    <= TRACK;
            miss_cnt <= '0;
          end
        end
        default: begin
          state         <= SEARCH;
          detected_flag <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/face_rect_ctrl.md
Name: face_rect_ctrl

Overview:
Controller that sequences the rectangle-overlay stage from face-detector results. Accepts detection results over a valid/ready handshake into a shadow register and commits them only at frame start (vsync rising edge), so the overlay never tears mid-frame. Tracks hit/miss history across frames and drives rectangle coordinates, detected_flag and continuous to the draw_rectangle stage. Sits between the detector core and the VGA overlay pipeline, in the pclk domain.

Parameters:
H_ACTIVE, 640, active pixels per line; used for clamping
V_ACTIVE, 480, active lines per frame; used for clamping
HOLD_FRAMES, 3, consecutive missed frames tolerated before the rectangle is dropped (0 = drop on first miss)
CW, 12, coordinate width, matching hcount/vcount

Ports:
pclk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
vsync_in  in  1  VGA vsync from the timing generator
det_valid  in  1  detector result valid
det_ready  out  1  controller can accept a result
det_found  in  1  result contains a face
det_x  in  CW  box left edge
det_y  in  CW  box top edge
det_w  in  CW  box width
det_h  in  CW  box height
mode_continuous  in  1  1 = track every frame; 0 = one-shot freeze
clear  in  1  single-cycle pulse; releases a frozen rectangle
rect_x, rect_y, rect_w, rect_h  out  CW each  committed rectangle for the draw stage
detected_flag  out  1  rectangle shall be drawn
continuous  out  1  registered mode_continuous, sampled at frame_tick
frame_tick  out  1  one-cycle pulse on the vsync rising edge

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state=SEARCH; pending=0; miss_cnt=0; vsync_d=0; det_ready=0 while rst_n=0, and 1 from the first cycle after release.
- frame_tick = vsync_in & ~vsync_d, with vsync_d registered. The tick is combinational from the register pair. A vsync already high when reset releases produces no tick.
- Handshake: det_ready = ~pending. Transfer when det_valid & det_ready: the shadow loads {found,x,y,w,h} and pending is set. det_valid is honoured whenever it is high; the detector holds the result until ready.
- Commit: on frame_tick with pending=1, the shadow is evaluated and pending clears, so ready returns 1 the next cycle.
  - A transfer in the same cycle as a frame_tick with pending=0 waits for the next tick.
  - A frame_tick with pending=0 counts as a miss.
- Hit = committed found=1 and w≠0 and h≠0; anything else is a miss.
- Clamp on hit: x'=min(x,H_ACTIVE-1), y'=min(y,V_ACTIVE-1), w'=min(w,H_ACTIVE-x'), h'=min(h,V_ACTIVE-y'). Use CW+1-bit arithmetic with no wrap.
- FSM updates on frame_tick only, except for clear:
  - SEARCH: hit → TRACK if mode_continuous, else FROZEN; load rect_*.
  - TRACK: hit → update rect_*, miss_cnt=0. Miss → miss_cnt=1; go to HOLD if HOLD_FRAMES>0, else SEARCH.
  - HOLD: hit → TRACK, update rect_*, miss_cnt=0. Miss → miss_cnt+1; go to SEARCH when miss_cnt would exceed HOLD_FRAMES. rect_* is retained.
  - FROZEN: commits are drained but ignored. clear=1 (any cycle) → SEARCH next cycle. mode_continuous=1 at a tick → TRACK.
- Simultaneous clear and frame_tick in FROZEN: clear wins, and the tick's commit is discarded.
- detected_flag = (state≠SEARCH), registered. rect_* is held (not zeroed) on return to SEARCH.
- continuous is updated from mode_continuous on frame_tick only.
- miss_cnt saturates at HOLD_FRAMES+1, with width $clog2(HOLD_FRAMES+2).
- All outputs except frame_tick are registered. A hit seen at tick N appears on rect_*/detected_flag at N+1.

Decomposition:
- Package face_rect_pkg:
  - state enum SEARCH/TRACK/HOLD/FROZEN (2 bits)
  - default H_ACTIVE/V_ACTIVE/CW constants
  - result struct {found,x,y,w,h}
- One combinational sub-module, rect_clamp: takes x,y,w,h and returns the clamped x',y',w',h'. It is parameterised by H_ACTIVE, V_ACTIVE and CW.

Test Plan:
1. Reset, then a hit {1,100,150,64,48} before vsync → on vsync rise+1: rect=(100,150,64,48), detected_flag=1, state=TRACK. det_ready is 0 from accept until tick+1.
2. Clamp: hit {1,620,470,64,48} → rect=(620,470,20,10). Hit with w=0 → treated as miss.
3. Hold, HOLD_FRAMES=3, tracking: 3 ticks with no result → flag stays 1 and rect is unchanged. 4th tick → flag=0 at tick+1. A hit on the 2nd tick returns to TRACK with miss_cnt=0.
4. Handshake backpressure: two back-to-back results within one frame → the second stalls (ready=0) until tick+1, then commits at the following tick.
5. One-shot: mode_continuous=0, hit (10,20,30,40) → FROZEN. A later hit (200,200,50,50) is ignored. A clear pulse → flag=0 next cycle. clear coincident with a tick → commit discarded.
6. Async reset mid-TRACK (rst_n low for 3 ns between edges) → all outputs 0 immediately. With vsync held high through reset release, no frame_tick fires.
